// File: rtl/io_bus_pkg.sv
// Shared types and field positions for the IO device bus: arbiter states,
// command-word field positions and GPIO command codes.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } io_arb_state_e;

    localparam int IO_ADDR_MSB = 15;
    localparam int IO_ADDR_LSB = 13;
    localparam int IO_CMD_MSB  = 12;
    localparam int IO_CMD_LSB  = 10;

    typedef enum logic [2:0] {
        WRITE_BIT  = 3'd0,
        READ_BIT   = 3'd1,
        SET_BIT    = 3'd2,
        CLEAR_BIT  = 3'd3,
        TOGGLE_BIT = 3'd4,
        WRITE_PORT = 3'd5,
        READ_PORT  = 3'd6,
        PULSE_BIT  = 3'd7
    } gpio_cmd_e;

    function automatic gpio_cmd_e ioCmdOf(input logic [15:0] word);
        return gpio_cmd_e'(word[IO_CMD_MSB:IO_CMD_LSB]);
    endfunction

    function automatic logic [2:0] ioAddrOf(input logic [15:0] word);
        return word[IO_ADDR_MSB:IO_ADDR_LSB];
    endfunction

endpackage

// File: rtl/io_port_arbiter_if.sv
// Bundle of requester, device and response signals around io_port_arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface io_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        Req_Valid;
    logic [NUM_REQ-1:0]        Req_Ready;
    logic [NUM_REQ*DATA_W-1:0] Req_Data;
    logic [NUM_REQ*4-1:0]      Req_DestReg;
    logic [NUM_REQ-1:0]        Req_RespReq;

    logic                      Dev_REQ;
    logic                      Dev_ACK;
    logic                      Dev_CommandEn;
    logic                      Dev_RespReq;
    logic [3:0]                Dev_DestReg;
    logic [DATA_W-1:0]         Dev_Data;
    logic                      Dev_RegRespFlag;
    logic [DATA_W-1:0]         Dev_RespData;
    logic [3:0]                Dev_RespDestReg;

    logic [NUM_REQ-1:0]        Rsp_Valid;
    logic [DATA_W-1:0]         Rsp_Data;
    logic [3:0]                Rsp_DestReg;
    logic                      Rsp_Error;

    modport slave (
        input  Req_Valid, Req_Data, Req_DestReg, Req_RespReq,
        input  Dev_ACK, Dev_RegRespFlag, Dev_RespData, Dev_RespDestReg,
        output Req_Ready,
        output Dev_REQ, Dev_CommandEn, Dev_RespReq, Dev_DestReg, Dev_Data,
        output Rsp_Valid, Rsp_Data, Rsp_DestReg, Rsp_Error
    );

    modport master (
        output Req_Valid, Req_Data, Req_DestReg, Req_RespReq,
        output Dev_ACK, Dev_RegRespFlag, Dev_RespData, Dev_RespDestReg,
        input  Req_Ready,
        input  Dev_REQ, Dev_CommandEn, Dev_RespReq, Dev_DestReg, Dev_Data,
        input  Rsp_Valid, Rsp_Data, Rsp_DestReg, Rsp_Error
    );

endinterface

// File: rtl/io_port_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first valid
// requester found searching upward from Ptr, wrapping at NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         Valid,
    input  logic [$clog2(NUM_REQ)-1:0] Ptr,
    output logic [NUM_REQ-1:0]         Grant,
    output logic [$clog2(NUM_REQ)-1:0] Index
);
    localparam int IDX_W = $clog2(NUM_REQ);

    int               slotI;
    logic [IDX_W-1:0] slot;
    logic             found;

    always_comb begin
        Grant = '0;
        Index = '0;
        found = 1'b0;
        slotI = 0;
        slot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slotI = int'(Ptr) + i;
            if (slotI >= NUM_REQ) slotI = slotI - NUM_REQ;
            slot = slotI[IDX_W-1:0];
            if (!found && Valid[slot]) begin
                found       = 1'b1;
                Grant[slot] = 1'b1;
                Index       = slot;
            end
        end
    end

endmodule

// File: rtl/io_port_arbiter.sv
// Shares one IO device port between NUM_REQ requesters: round-robin accept,
// device REQ/ACK handshake, and response routing back to the owner.
module io_port_arbiter
    import io_bus_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              clk_en,
    io_port_arbiter_if.slave  bus
);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    io_arb_state_e       state;
    io_arb_state_e       nextState;
    logic [IDX_W-1:0]    ptr;
    logic [NUM_REQ-1:0]  pickGrant;
    logic [IDX_W-1:0]    pickIndex;

    logic [DATA_W-1:0]   reqWords [NUM_REQ];
    logic [3:0]          reqTags  [NUM_REQ];

    logic [DATA_W-1:0]   holdData;
    logic [3:0]          holdDest;
    logic                holdRespReq;
    logic [IDX_W-1:0]    holdOwner;
    logic [TIMER_W-1:0]  timer;

    logic [NUM_REQ-1:0]  rspValidReg;
    logic [DATA_W-1:0]   rspData;
    logic [3:0]          rspDest;
    logic                rspError;

    logic accept;
    logic capture;
    logic timeoutHit;
    logic timerClear;
    logic timerInc;

    rr_pick #(.NUM_REQ(NUM_REQ)) picker (
        .Valid (bus.Req_Valid),
        .Ptr   (ptr),
        .Grant (pickGrant),
        .Index (pickIndex)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqWords[i] = bus.Req_Data[i*DATA_W +: DATA_W];
            reqTags[i]  = bus.Req_DestReg[i*4 +: 4];
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n)  state <= IDLE;
        else if (clk_en)   state <= nextState;
    end

    // A response arriving with the ACK wins over parking in WAIT_RSP; in
    // WAIT_RSP a real response wins over a coincident timeout.
    always_comb begin
        nextState  = state;
        accept     = 1'b0;
        capture    = 1'b0;
        timeoutHit = 1'b0;
        timerClear = 1'b0;
        timerInc   = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.Req_Valid) begin
                    accept    = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.Dev_ACK) begin
                    if (!holdRespReq) begin
                        nextState = IDLE;
                    end else if (bus.Dev_RegRespFlag) begin
                        capture   = 1'b1;
                        nextState = IDLE;
                    end else begin
                        timerClear = 1'b1;
                        nextState  = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (bus.Dev_RegRespFlag) begin
                    capture   = 1'b1;
                    nextState = IDLE;
                end else if (TIMEOUT != 0 && int'(timer) == TIMEOUT - 1) begin
                    timeoutHit = 1'b1;
                    nextState  = IDLE;
                end else begin
                    timerInc = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            ptr         <= '0;
            holdData    <= '0;
            holdDest    <= '0;
            holdRespReq <= 1'b0;
            holdOwner   <= '0;
            timer       <= '0;
        end else if (clk_en) begin
            if (accept) begin
                holdData    <= reqWords[pickIndex];
                holdDest    <= reqTags[pickIndex];
                holdRespReq <= bus.Req_RespReq[pickIndex];
                holdOwner   <= pickIndex;
                ptr         <= (int'(pickIndex) == NUM_REQ - 1) ? '0 : pickIndex + IDX_W'(1);
            end
            if (timerClear)     timer <= '0;
            else if (timerInc)  timer <= timer + TIMER_W'(1);
        end
    end

    // Response registers: the valid pulse lives for one enabled cycle only.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rspValidReg <= '0;
            rspData     <= '0;
            rspDest     <= '0;
            rspError    <= 1'b0;
        end else if (clk_en) begin
            rspValidReg <= '0;
            if (capture || timeoutHit) begin
                rspValidReg[holdOwner] <= 1'b1;
                rspData                <= timeoutHit ? '0 : bus.Dev_RespData;
                rspDest                <= timeoutHit ? holdDest : bus.Dev_RespDestReg;
                rspError               <= timeoutHit;
            end
        end
    end

    assign bus.Req_Ready     = (state == IDLE && clk_en && async_rst_n) ? pickGrant : '0;
    assign bus.Dev_REQ       = (state == ISSUE) && clk_en;
    assign bus.Dev_CommandEn = (state == ISSUE);
    assign bus.Dev_RespReq   = holdRespReq;
    assign bus.Dev_DestReg   = holdDest;
    assign bus.Dev_Data      = holdData;
    assign bus.Rsp_Valid     = rspValidReg & {NUM_REQ{clk_en}};
    assign bus.Rsp_Data      = rspData;
    assign bus.Rsp_DestReg   = rspDest;
    assign bus.Rsp_Error     = rspError;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Scoreboard bench for io_port_arbiter: directed transactions push expected
// grants, device issues and responses; negedge monitors pop and compare.
module tb_io_port_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic async_rst_n;
    logic clk_en;

    io_port_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    io_port_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .clk_en      (clk_en),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dest;
        logic        respReq;
    } issue_t;

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] data;
        logic [3:0]  dest;
        logic        err;
        int          cycle;
    } rsp_t;

    int     expGrant [$];
    issue_t expIssue [$];
    rsp_t   expRsp   [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] data, input logic [3:0] dest, input logic respReq);
        bus.Req_Data[idx*DW +: DW]  = data;
        bus.Req_DestReg[idx*4 +: 4] = dest;
        bus.Req_RespReq[idx]        = respReq;
        bus.Req_Valid               = 4'b0001 << idx;
    endtask

    task automatic expectIssue(input logic [15:0] data, input logic [3:0] dest, input logic respReq);
        issue_t e;
        e.data = data; e.dest = dest; e.respReq = respReq;
        expIssue.push_back(e);
    endtask

    task automatic expectRsp(input logic [3:0] valid, input logic [15:0] data, input logic [3:0] dest,
                             input logic err, input int cycle);
        rsp_t e;
        e.valid = valid; e.data = data; e.dest = dest; e.err = err; e.cycle = cycle;
        expRsp.push_back(e);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " Req_Ready"}, 32'(bus.Req_Ready), 0);
        checkOutput({tag, " Dev ctl"}, {29'd0, bus.Dev_REQ, bus.Dev_CommandEn, bus.Dev_RespReq}, 0);
        checkOutput({tag, " Dev_Data/DestReg"}, {12'd0, bus.Dev_DestReg, bus.Dev_Data}, 0);
        checkOutput({tag, " Rsp_Valid/Error"}, {27'd0, bus.Rsp_Error, bus.Rsp_Valid}, 0);
        checkOutput({tag, " Rsp_Data/DestReg"}, {12'd0, bus.Rsp_DestReg, bus.Rsp_Data}, 0);
    endtask

    // Grant, device-issue and response monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.Req_Ready !== '0) begin
            if (expGrant.size() == 0) checkOutput("unexpected grant", 32'(bus.Req_Ready), 0);
            else checkOutput("grant", 32'(bus.Req_Ready), 32'(1) << expGrant.pop_front());
        end
        if (bus.Dev_REQ === 1'b1 && bus.Dev_ACK === 1'b1) begin
            if (expIssue.size() == 0) begin
                checkOutput("unexpected issue", 32'(bus.Dev_Data), 0);
            end else begin
                issue_t e;
                e = expIssue.pop_front();
                checkOutput("issue Dev_Data", 32'(bus.Dev_Data), 32'(e.data));
                checkOutput("issue Dev_DestReg/RespReq/CmdEn",
                            {26'd0, bus.Dev_DestReg, bus.Dev_RespReq, bus.Dev_CommandEn},
                            {26'd0, e.dest, e.respReq, 1'b1});
            end
        end
        if (bus.Rsp_Valid !== '0) begin
            if (expRsp.size() == 0) begin
                checkOutput("unexpected Rsp_Valid", 32'(bus.Rsp_Valid), 0);
            end else begin
                rsp_t e;
                e = expRsp.pop_front();
                checkOutput("Rsp_Valid", 32'(bus.Rsp_Valid), 32'(e.valid));
                checkOutput("Rsp_Data", 32'(bus.Rsp_Data), 32'(e.data));
                checkOutput("Rsp_DestReg/Error", {27'd0, bus.Rsp_DestReg, bus.Rsp_Error}, {27'd0, e.dest, e.err});
                if (e.cycle >= 0) checkOutput("Rsp cycle", 32'(cyc), 32'(e.cycle));
            end
        end
    end

    initial begin
        int k;
        async_rst_n         = 1'b0;
        clk_en              = 1'b1;
        bus.Req_Valid       = 4'b0101;
        bus.Req_Data        = '0;
        bus.Req_DestReg     = '0;
        bus.Req_RespReq     = '0;
        bus.Dev_ACK         = 1'b0;
        bus.Dev_RegRespFlag = 1'b0;
        bus.Dev_RespData    = '0;
        bus.Dev_RespDestReg = '0;
        #3;
        checkResetOutputs("power-on reset");
        tick();
        tick();
        bus.Req_Valid = '0;
        async_rst_n   = 1'b1;
        tick();

        // No-response write from requester 0.
        bus.Dev_ACK = 1'b1;
        applyStimulus(0, 16'h2001, 4'h0, 1'b0);
        expGrant.push_back(0);
        expectIssue(16'h2001, 4'h0, 1'b0);
        tick();
        bus.Req_Valid = '0;
        repeat (3) tick();

        // Read answered together with the ACK; pointer now at 1, so 2 wins.
        applyStimulus(2, 16'h0C00, 4'h5, 1'b1);
        bus.Dev_RegRespFlag = 1'b1;
        bus.Dev_RespData    = 16'h0001;
        bus.Dev_RespDestReg = 4'h5;
        k = cyc;
        expGrant.push_back(2);
        expectIssue(16'h0C00, 4'h5, 1'b1);
        expectRsp(4'b0100, 16'h0001, 4'h5, 1'b0, k + 2);
        tick();
        bus.Req_Valid = '0;
        repeat (2) tick();
        bus.Dev_RegRespFlag = 1'b0;
        repeat (2) tick();

        // Round-robin from a freshly reset pointer with everyone requesting.
        async_rst_n = 1'b0;
        #2;
        checkResetOutputs("re-reset");
        tick();
        async_rst_n = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) begin
            bus.Req_Data[i*DW +: DW]  = 16'h1000 + 16'(i);
            bus.Req_DestReg[i*4 +: 4] = 4'(i);
            bus.Req_RespReq[i]        = 1'b0;
        end
        for (int n = 0; n < 6; n++) begin
            expGrant.push_back(n % NR);
            expectIssue(16'h1000 + 16'(n % NR), 4'(n % NR), 1'b0);
        end
        bus.Req_Valid = 4'b1111;
        repeat (11) tick();
        bus.Req_Valid = '0;
        repeat (2) tick();

        // Timeout: pointer at 2 with only requester 3 valid; device never answers.
        applyStimulus(3, 16'h4400, 4'hA, 1'b1);
        k = cyc;
        expGrant.push_back(3);
        expectIssue(16'h4400, 4'hA, 1'b1);
        expectRsp(4'b1000, 16'h0000, 4'hA, 1'b1, k + 10);
        tick();
        bus.Req_Valid = '0;
        repeat (10) tick();
        bus.Dev_RegRespFlag = 1'b1;
        bus.Dev_RespData    = 16'hBEEF;
        repeat (3) tick();
        bus.Dev_RegRespFlag = 1'b0;
        tick();

        // clk_en gating, first in IDLE then while holding in ISSUE with ACK high.
        clk_en = 1'b0;
        applyStimulus(0, 16'h8123, 4'h3, 1'b0);
        #3;
        checkOutput("gated idle Req_Ready", 32'(bus.Req_Ready), 0);
        tick();
        #3;
        checkOutput("gated idle Req_Ready 2", 32'(bus.Req_Ready), 0);
        tick();
        expGrant.push_back(0);
        expectIssue(16'h8123, 4'h3, 1'b0);
        clk_en = 1'b1;
        tick();
        bus.Req_Valid = 4'b0010;
        clk_en        = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #3;
            checkOutput("gated ISSUE Dev_REQ", {31'd0, bus.Dev_REQ}, 0);
            checkOutput("gated ISSUE CommandEn", {31'd0, bus.Dev_CommandEn}, 1);
            checkOutput("gated ISSUE Req_Ready", 32'(bus.Req_Ready), 0);
            tick();
        end
        bus.Req_Valid = '0;
        clk_en        = 1'b1;
        repeat (3) tick();

        // Reset in WAIT_RSP: pointer at 1, so requester 1 owns the transaction.
        applyStimulus(1, 16'h2222, 4'h7, 1'b1);
        expGrant.push_back(1);
        expectIssue(16'h2222, 4'h7, 1'b1);
        tick();
        bus.Req_Valid = '0;
        repeat (3) tick();
        bus.Req_Valid = 4'b0100;
        #1;
        async_rst_n = 1'b0;
        #1;
        checkResetOutputs("mid-op reset");
        tick();
        tick();
        bus.Req_Valid = '0;
        async_rst_n   = 1'b1;
        repeat (12) tick();
        applyStimulus(0, 16'h5A5A, 4'h9, 1'b0);
        bus.Req_Valid = 4'b1111;
        expGrant.push_back(0);
        expectIssue(16'h5A5A, 4'h9, 1'b0);
        tick();
        bus.Req_Valid = '0;
        repeat (3) tick();

        checkOutput("grant queue drained", 32'(expGrant.size()), 0);
        checkOutput("issue queue drained", 32'(expIssue.size()), 0);
        checkOutput("response queue drained", 32'(expRsp.size()), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
